// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS-style control unit.
// Sequence: FETCH -> DECODE -> EXEC -> MEM -> WB, plus a TRAP state for
// syscall, cop0 and unknown opcodes. Every strobe is decoded from the current
// state, the live handshakes and rst, so FETCH, MEM and TRAP can respond to
// mem_ready/trap_ack, and reset can blank the outputs, in the same cycle.
module mc_ctrl_fsm #(
    parameter int MEM_HS  = 1,
    parameter int EXC_EN  = 1,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    input  logic               mem_ready,
    input  logic               trap_ack,
    output logic               pc_write,
    output logic               ir_write,
    output logic               mem_req,
    output logic               mem_we,
    output logic               reg_write,
    output logic               alusrc,
    output logic               regdst,
    output logic               memtoreg,
    output logic               branch,
    output logic               bneorbeq,
    output logic               jump,
    output logic               isjal,
    output logic               isjr,
    output logic               zeroextend,
    output logic               iscop0,
    output logic               trap,
    output logic [ALUOP_W-1:0] aluop,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_COP0  = 6'b010000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;

    state_t           state_q, state_d;
    logic [5:0]       op_q, func_q;
    logic [CNT_W-1:0] retired_q;

    logic [5:0] cur_op, cur_func;
    logic       mem_done;
    logic       is_rtype, is_imm_alu, is_logic_imm, is_branch, is_load, is_store;
    logic       is_legal, retire;

    // ALU operation for an instruction; R-type decodes func, I-type decodes op
    function automatic logic [3:0] alu_code(input logic [5:0] o, input logic [5:0] f);
        logic [3:0] c;
        c = ALU_ADD;
        if (o == OP_RTYPE) begin
            casez (f)
                6'b10000?: c = ALU_ADD;
                6'b10001?: c = ALU_SUB;
                6'b100100: c = ALU_AND;
                6'b100101: c = ALU_OR;
                6'b100110: c = ALU_XOR;
                6'b100111: c = ALU_NOR;
                6'b101010: c = ALU_SLT;
                6'b101011: c = ALU_SLTU;
                6'b000000: c = ALU_SLL;
                6'b000010: c = ALU_SRL;
                6'b000011: c = ALU_SRA;
                default:   c = ALU_ADD;
            endcase
        end else begin
            case (o)
                OP_BEQ, OP_BNE: c = ALU_SUB;
                OP_ANDI:        c = ALU_AND;
                OP_ORI:         c = ALU_OR;
                OP_XORI:        c = ALU_XOR;
                OP_SLTI:        c = ALU_SLT;
                OP_SLTIU:       c = ALU_SLTU;
                default:        c = ALU_ADD;
            endcase
        end
        return c;
    endfunction

    // DECODE looks at the live IR; later states use the copy latched in DECODE
    assign cur_op   = (state_q == ST_DECODE) ? op   : op_q;
    assign cur_func = (state_q == ST_DECODE) ? func : func_q;

    // With the handshake disabled memory is treated as always ready
    assign mem_done = (MEM_HS == 0) || mem_ready;

    assign is_rtype     = (cur_op == OP_RTYPE);
    assign is_branch    = (cur_op == OP_BEQ) || (cur_op == OP_BNE);
    assign is_load      = (cur_op == OP_LW);
    assign is_store     = (cur_op == OP_SW);
    assign is_logic_imm = (cur_op == OP_ANDI) || (cur_op == OP_ORI) || (cur_op == OP_XORI);
    assign is_imm_alu   = (cur_op[5:3] == 3'b001) && (cur_op[2:0] != 3'b111);

    // Opcodes the datapath understands; anything else traps in DECODE
    always_comb begin
        case (cur_op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI,
            OP_COP0, OP_LW, OP_SW: is_legal = 1'b1;
            default:               is_legal = 1'b0;
        endcase
    end

    // Next-state and strobe decode for the current state; rst blanks everything
    always_comb begin
        state_d    = ST_FETCH;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_write  = 1'b0;
        alusrc     = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        branch     = 1'b0;
        bneorbeq   = 1'b0;
        jump       = 1'b0;
        isjal      = 1'b0;
        isjr       = 1'b0;
        zeroextend = 1'b0;
        iscop0     = 1'b0;
        trap       = 1'b0;
        aluop      = '0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_done) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = ST_DECODE;
                    end else begin
                        state_d  = ST_FETCH;
                    end
                end
                ST_DECODE: begin
                    iscop0 = (cur_op == OP_COP0);
                    if (cur_op == OP_J) begin
                        jump     = 1'b1;
                        pc_write = 1'b1;
                        state_d  = ST_FETCH;
                    end else if (cur_op == OP_JAL) begin
                        jump      = 1'b1;
                        isjal     = 1'b1;
                        reg_write = 1'b1;
                        pc_write  = 1'b1;
                        state_d   = ST_FETCH;
                    end else if (is_rtype && (cur_func == FN_JR)) begin
                        isjr     = 1'b1;
                        pc_write = 1'b1;
                        state_d  = ST_FETCH;
                    end else if ((is_rtype && (cur_func == FN_SYSCALL)) ||
                                 (cur_op == OP_COP0) || !is_legal) begin
                        state_d = (EXC_EN != 0) ? ST_TRAP : ST_FETCH;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    aluop      = ALUOP_W'(alu_code(cur_op, cur_func));
                    alusrc     = is_imm_alu || is_load || is_store;
                    zeroextend = is_logic_imm;
                    if (is_branch) begin
                        branch   = 1'b1;
                        bneorbeq = (cur_op == OP_BNE);
                        state_d  = ST_FETCH;
                    end else if (is_load || is_store) begin
                        state_d = ST_MEM;
                    end else begin
                        state_d = ST_WB;
                    end
                end
                ST_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = is_store;
                    if (mem_done) begin
                        state_d = is_store ? ST_FETCH : ST_WB;
                    end else begin
                        state_d = ST_MEM;
                    end
                end
                ST_WB: begin
                    reg_write = 1'b1;
                    regdst    = is_rtype;
                    memtoreg  = is_load;
                    state_d   = ST_FETCH;
                end
                ST_TRAP: begin
                    trap = 1'b1;
                    if (trap_ack) begin
                        pc_write = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d  = ST_TRAP;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    // An instruction retires when control returns to FETCH, except out of TRAP
    assign retire = (state_d == ST_FETCH) && (state_q != ST_FETCH) && (state_q != ST_TRAP);

    // State register, IR field latch and retired-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            op_q      <= '0;
            func_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q   <= op;
                func_q <= func;
            end
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 Parameters: MEM_HS (default 1, 1 = wait on mem_ready, 0 = memory always ready), EXC_EN (default 1, 1 = TRAP state enabled), ALUOP_W (default 4, aluop width, minimum 4), CNT_W (default 32, retired-instruction counter width).
REQ-002 Ports: clk in 1, clock, all state changes on the rising edge.
REQ-003 rst in 1, reset, synchronous, active-high.
REQ-004 op in 6, opcode held by the IR; func in 6, funct field.
REQ-005 mem_ready in 1, memory access complete; trap_ack in 1, trap handler accepted.
REQ-006 Outputs, each 1 bit: pc_write, ir_write, mem_req, mem_we, reg_write, alusrc, regdst, memtoreg, branch, bneorbeq, jump, isjal, isjr, zeroextend, iscop0, trap.
REQ-007 aluop out ALUOP_W, ALU code, zero-extended from 4 bits; state out 3, current state; retired out CNT_W, count of retired instructions.

Function
REQ-010 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 SHALL go to FETCH on the next cycle.
REQ-011 op/func SHALL be captured into op_q/func_q on the DECODE cycle; all decode outputs in EXEC/MEM/WB SHALL use op_q/func_q.
REQ-012 FETCH: mem_req=1, mem_we=0; when mem_ready (or MEM_HS=0): ir_write=1, pc_write=1, next DECODE; otherwise hold FETCH with ir_write=pc_write=0.
REQ-013 DECODE, j (000010): jump=pc_write=1, next FETCH.
REQ-014 DECODE, jal (000011): jump=isjal=reg_write=pc_write=1, next FETCH.
REQ-015 DECODE, jr (op 0, func 001000): isjr=pc_write=1, next FETCH.
REQ-016 DECODE, syscall (op 0, func 001100), cop0 (010000) or unlisted opcode: next TRAP if EXC_EN=1, else FETCH as a no-op; iscop0=1 in DECODE when op=010000.
REQ-017 DECODE, all other opcodes: next EXEC.
REQ-018 Legal opcodes: R-type 000000, addi 001000, addiu 001001, slti 001010, sltiu 001011, andi 001100, ori 001101, xori 001110, beq 000100, bne 000101, lw 100011, sw 101011, j, jal, cop0.
REQ-019 ALU codes SHALL be ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, SRA=10.
REQ-020 R-type func mapping: 10000x ADD, 10001x SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 101011 SLTU, 000000 SLL, 000010 SRL, 000011 SRA, others ADD.
REQ-021 I-type mapping: addi/addiu/lw/sw ADD, beq/bne SUB, andi AND, ori OR, xori XOR, slti SLT, sltiu SLTU.
REQ-022 EXEC: aluop valid; alusrc=1 for all I-type except beq/bne; zeroextend=1 for andi/ori/xori.
REQ-023 EXEC, beq/bne: branch=1, bneorbeq=1 for bne only, next FETCH.
REQ-024 EXEC, lw/sw: next MEM; all other instructions: next WB.
REQ-025 MEM: mem_req=1, mem_we=1 for sw only; hold until mem_ready (or MEM_HS=0); then sw goes to FETCH and lw goes to WB.
REQ-026 WB: reg_write=1; regdst=1 for R-type; memtoreg=1 for lw; next FETCH.
REQ-027 TRAP: trap=1 and pc_write=0 while held; trap_ack=1 gives pc_write=1 and next FETCH.
REQ-028 All strobes SHALL be 0 in states where this document does not assert them.
REQ-029 retired SHALL increment by 1 on every transition into FETCH from any state except TRAP, wrapping modulo 2^CNT_W.

Reset
REQ-030 Any cycle with rst=1: next state FETCH, op_q=func_q=0, retired=0, all strobes and aluop forced to 0 in that cycle.
REQ-031 rst asserted mid-operation (in MEM waiting, or in TRAP) SHALL abandon the instruction without a retire increment.
REQ-032 Normal sequencing SHALL begin from FETCH on the first cycle after rst falls.

Verification
REQ-040 add (op 0, func 100000), mem_ready=1: FETCH, DECODE, EXEC, WB, FETCH; WB has reg_write=1, regdst=1, aluop=0; retired=1.
REQ-041 lw with mem_ready low 3 cycles in MEM: MEM held 3 extra cycles with mem_req=1, mem_we=0; then WB has memtoreg=1; retired +1.
REQ-042 bne: 3-cycle instruction; EXEC has branch=1, bneorbeq=1, aluop=1, alusrc=0.
REQ-043 syscall, EXEC_EN=1: TRAP held with trap=1 until trap_ack, then FETCH, retired unchanged; with EXC_EN=0: DECODE goes directly to FETCH.
REQ-044 CNT_W=4: 16 retired j instructions -> retired wraps 15 to 0.
REQ-045 rst pulsed while in MEM: next cycle state=0, all strobes 0, retired=0.
